can_tx_scheduler: RTL

Shares the single transmit interface of the simple CAN controller among NUM_REQ independent requesters. Each requester supplies an 11-bit ID and a 64-bit payload. The scheduler grants requesters round-robin, drives tx_id/tx_data/tx_start_strobe, and waits for tx_succeed or tx_failed. On failure or timeout it retries after a programmable backoff, up to MAX_RETRY times, then reports per-requester completion status. It sits between application logic (e.g. the periodic counter transmitter) and can_simple_top.

---
 rtl/can_tx_scheduler.sv | 87 ++++++++
 1 files changed

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: round-robin sharing of one CAN transmit interface with timeout, retry/backoff and per-requester done status
module can_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_GAP  = 1000,
  parameter int TX_TIMEOUT = 50_000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [11*NUM_REQ-1:0] req_id_i,
  input  logic [64*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ack_o,
  output logic [NUM_REQ-1:0]    req_done_o,
  output logic                  req_ok_o,
  output logic [10:0]           tx_id_o,
  output logic [63:0]           tx_data_o,
  output logic                  tx_start_strobe_o,
  input  logic                  tx_succeed_i,
  input  logic                  tx_failed_i,
  output logic                  busy_o
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TX_TIMEOUT > RETRY_GAP ? TX_TIMEOUT : RETRY_GAP) + 1;
  typedef enum logic [2:0] {IDLE, START, WAIT, BACKOFF, DONE} state_t;
  state_t state, nxt;
  logic [GW-1:0] g, sel;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] timer;
  logic [NUM_REQ-1:0] rot;
  logic [10:0] ids [NUM_REQ];
  logic [63:0] dats [NUM_REQ];
  logic ok, timeout, retry;
  int off;
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign ids[k]  = req_id_i[11*k +: 11];
    assign dats[k] = req_data_i[64*k +: 64];
  end
  always_comb begin
    rot = NUM_REQ'({req_valid_i, req_valid_i} >> (int'(g) + 1));
    off = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? i : off;
    sel = GW'((int'(g) + 1 + off) % NUM_REQ);
  end
  assign timeout = timer == TW'(TX_TIMEOUT - 1);
  assign retry   = retry_cnt < RW'(MAX_RETRY);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req_valid_i ? START : IDLE;
      START:   nxt = WAIT;
      WAIT:    nxt = tx_succeed_i ? DONE : (tx_failed_i || timeout) ? (retry ? BACKOFF : DONE) : WAIT;
      BACKOFF: nxt = timer == TW'(RETRY_GAP - 1) ? START : BACKOFF;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      g         <= GW'(NUM_REQ - 1);
      retry_cnt <= '0;
      timer     <= '0;
      ok        <= 1'b0;
      tx_id_o   <= '0;
      tx_data_o <= '0;
    end else begin
      timer <= (nxt == state && (state == WAIT || state == BACKOFF)) ? timer + 1'b1 : '0;
      if (state == IDLE && |req_valid_i) begin
        g         <= sel;
        retry_cnt <= '0;
        tx_id_o   <= ids[sel];
        tx_data_o <= dats[sel];
      end
      if (state == WAIT && nxt == BACKOFF) retry_cnt <= retry_cnt + 1'b1;
      if (state == WAIT && nxt == DONE) ok <= tx_succeed_i;
    end
  always_comb begin
    req_ack_o         = (state == IDLE && |req_valid_i && rst_n_i) ? NUM_REQ'(1) << sel : '0;
    req_done_o        = state == DONE ? NUM_REQ'(1) << g : '0;
    req_ok_o          = state == DONE && ok;
    tx_start_strobe_o = state == START;
    busy_o            = state != IDLE;
  end
endmodule
